// File: rtl/seg_pkg.sv
// Shared seven-segment constants: bit positions within seg and the 0..F glyph table.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;

  // Active-high a..g patterns indexed by nibble value.
  localparam seg7_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_encode.sv
// Combinational nibble to a..g lookup; nibbles above 9 go dark unless hex_en.
module seg_encode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_TABLE[nibble];
    if (nibble > 4'd9 && !hex_en) segs = SEG_BLANK;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with shadow/display registers that commit
// only at frame wrap, so a new value never appears half-drawn.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int HEX_EN         = 0,
  parameter int LZB_EN         = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_val, disp_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic                    rst_q;
  logic                    slot_end, wrap;
  logic [3:0]              nibble;
  logic                    lead_zero;
  logic [6:0]              enc;
  logic [7:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   dig_raw;

  assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
  assign wrap     = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      disp_val    <= '0;
      disp_dp     <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) idx <= wrap ? '0 : idx + IDX_W'(1);
      frame_start <= wrap;
      // Commit takes the pre-edge shadow, so a simultaneous load waits a frame.
      if (wrap) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end else if (wrap) begin
        pending    <= 1'b0;
      end
    end
  end

  // Select the scanned nibble and decide whether it is a leading zero.
  always_comb begin
    nibble    = 4'h0;
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) nibble = disp_val[4*i +: 4];
      if (IDX_W'(i) >= idx && disp_val[4*i +: 4] != 4'h0) lead_zero = 1'b0;
    end
    if (idx == '0 || LZB_EN == 0) lead_zero = 1'b0;
  end

  seg_encode u_encode (
    .nibble (nibble),
    .hex_en (1'(HEX_EN != 0)),
    .segs   (enc)
  );

  // Digit is dark for the first clock of every slot to hide segment switching.
  always_comb begin
    seg_raw                = 8'h00;
    seg_raw[SEG_G:SEG_A]   = lead_zero ? SEG_BLANK : enc;
    seg_raw[SEG_DP]        = disp_dp[idx];
    dig_raw                = '0;
    if (cnt != '0 && !blank) dig_raw[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset || rst_q) begin
      seg <= SEG_OFF;
      dig <= DIG_OFF;
    end else begin
      seg <= seg_raw ^ SEG_OFF;
      dig <= dig_raw ^ DIG_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: an active-high decimal instance and an inverted hex
// instance share stimulus; a time-indexed model predicts every output cycle.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int W  = 26;

  logic          clk = 1'b0;
  logic          reset, load, blank;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [7:0]    seg0, seg1;
  logic [3:0]    dig0, dig1;
  logic          fs0, fs1, pend0, pend1;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            failures = 0;

  int            m_t;
  bit            m_after_rst;
  logic [15:0]   m_shadow, m_disp;
  logic [3:0]    m_sdp, m_ddp;
  bit            m_pend;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_EN(0), .LZB_EN(1),
                    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_dec (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank(blank), .seg(seg0), .dig(dig0), .frame_start(fs0), .pending(pend0));

  seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_EN(1), .LZB_EN(1),
                    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_hex (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank(blank), .seg(seg1), .dig(dig1), .frame_start(fs1), .pending(pend1));

  function automatic logic [7:0] ref_seg(input logic [15:0] v, input logic [3:0] dp,
                                         input int i, input bit hex);
    logic [6:0] tbl [16];
    logic [3:0] n;
    logic [6:0] s;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    n = v[4*i +: 4];
    s = (n > 4'd9 && !hex) ? 7'h00 : tbl[n];
    if (i > 0 && (v >> (4*i)) == 16'h0) s = 7'h00;
    return {dp[i], s};
  endfunction

  // One clock: apply inputs, predict the outputs after this edge, queue them.
  task automatic cycle(input bit rst, input bit ld, input logic [15:0] v,
                       input logic [3:0] dp, input bit bl);
    logic [7:0] s0, s1;
    logic [3:0] d;
    bit         wrap;
    int         cnt, idx;
    reset = rst; load = ld; value = v; dp_in = dp; blank = bl;
    s0 = 8'h00; s1 = 8'h00; d = 4'h0; wrap = 1'b0;
    if (rst) begin
      m_t = 0; m_after_rst = 1'b1; m_pend = 1'b0;
      m_shadow = 16'h0; m_sdp = 4'h0; m_disp = 16'h0; m_ddp = 4'h0;
    end else begin
      cnt = m_t % SD;
      idx = (m_t / SD) % ND;
      if (!m_after_rst) begin
        d  = (cnt == 0 || bl) ? 4'h0 : 4'(1 << idx);
        s0 = ref_seg(m_disp, m_ddp, idx, 1'b0);
        s1 = ref_seg(m_disp, m_ddp, idx, 1'b1);
      end
      wrap = ((m_t + 1) % (SD * ND)) == 0;
      if (wrap) begin m_disp = m_shadow; m_ddp = m_sdp; end
      if (ld) begin m_shadow = v; m_sdp = dp; m_pend = 1'b1; end
      else if (wrap) m_pend = 1'b0;
      m_t++;
      m_after_rst = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_q.push_back({wrap, m_pend, s0, d, ~s1, ~d});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every output cycle is compared against the oldest prediction.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame_start", {7'h0, fs0},   {7'h0, e[25]});
        chk("pending",     {7'h0, pend0}, {7'h0, e[24]});
        chk("seg_dec",     seg0,          e[23:16]);
        chk("dig_dec",     {4'h0, dig0},  {4'h0, e[15:12]});
        chk("seg_hex_inv", seg1,          e[11:4]);
        chk("dig_hex_inv", {4'h0, dig1},  {4'h0, e[3:0]});
        chk("inst_agree",  {6'h0, fs1, pend1}, {6'h0, e[25], e[24]});
      end
    end
  end

  initial begin
    reset = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank = 1'b0;
    repeat (2) cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(40);

    // Mid-frame load shows only after the next wrap.
    idle(5);
    cycle(1'b0, 1'b1, 16'h0120, 4'b0010, 1'b0);
    idle(40);

    // Load at the wrap cycle: old shadow commits, new value waits a frame.
    for (int k = 0; k < 16 && (m_t % 16) != 3; k++) idle(1);
    cycle(1'b0, 1'b1, 16'h0005, 4'b0000, 1'b0);
    for (int k = 0; k < 16 && (m_t % 16) != 15; k++) idle(1);
    cycle(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);
    idle(36);

    cycle(1'b0, 1'b1, 16'h00AF, 4'b0001, 1'b0);
    idle(36);

    repeat (10) cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    idle(6);

    for (int k = 0; k < 4 && (m_t % SD) != 2; k++) idle(1);
    cycle(1'b1, 1'b1, 16'h9999, 4'hF, 1'b0);
    idle(20);

    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0,
            16'($urandom), 4'($urandom), $urandom_range(0, 9) == 0);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
